// File: rtl/sfu_pkg.sv
// Shared widths and the saturating clamp helper for the SFU requant slice.
package sfu_pkg;

  localparam int Q_W   = 5;
  localparam int SH_W  = 6;
  localparam int SAT_W = 64;

  typedef struct packed {
    logic                    sat;
    logic signed [SAT_W-1:0] val;
  } sat_res_t;

  // Clamp a wide signed value into an out_w-bit two's complement range.
  function automatic sat_res_t sat_signed(input logic signed [SAT_W-1:0] v,
                                          input int unsigned             out_w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sat_res_t                res;
    hi      = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo      = -hi - 64'sd1;
    res.sat = 1'b0;
    res.val = v;
    if (v > hi) begin
      res.sat = 1'b1;
      res.val = hi;
    end else if (v < lo) begin
      res.sat = 1'b1;
      res.val = lo;
    end
    return res;
  endfunction

endpackage

// File: rtl/sfu_sync_fifo.sv
// Synchronous FIFO with flop-based storage, occupancy count and full/empty flags.
module sfu_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sfu_requant_unit.sv
// Requantises SFU log-stage results to a configured output Q with round-half-up and
// saturation, buffering them in a small FIFO with almost_full and sticky overflow reporting.
module sfu_requant_unit
  import sfu_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Q_W-1:0]   cfg_out_Q,
  input  logic [IN_W-1:0]  data_in,
  input  logic [Q_W-1:0]   data_in_Q,
  input  logic             valid_in,
  output logic [OUT_W-1:0] data_out,
  output logic [Q_W-1:0]   data_out_Q,
  output logic             sat_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic             almost_full,
  output logic             ovf_err,
  input  logic             err_clr
);

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [Q_W-1:0]   q;
    logic             sat;
  } entry_t;

  logic                   s1_valid_q, s1_valid_d;
  logic signed [IN_W-1:0] s1_data_q, s1_data_d;
  logic signed [SH_W-1:0] s1_sh_q, s1_sh_d;
  logic [Q_W-1:0]         s1_q_q, s1_q_d;
  logic                   s2_valid_q, s2_valid_d;
  entry_t                 s2_entry_q, s2_entry_d;
  logic                   almost_full_q, almost_full_d;
  logic                   ovf_err_q, ovf_err_d;

  logic signed [SAT_W-1:0] s2_wide;
  sat_res_t                s2_res;
  int                      sh_i;
  int                      sh_amt;

  entry_t                  head;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic                    fifo_full, fifo_empty;
  logic                    pop, drop;

  always_comb begin
    s1_valid_d = valid_in;
    s1_data_d  = s1_data_q;
    s1_sh_d    = s1_sh_q;
    s1_q_d     = s1_q_q;
    if (valid_in) begin
      s1_data_d = data_in;
      s1_sh_d   = {1'b0, data_in_Q} - {1'b0, cfg_out_Q};
      s1_q_d    = cfg_out_Q;
    end
  end

  // Right shifts clamp at IN_W; left shifts clamp at OUT_W, which already
  // guarantees saturation for any nonzero value.
  always_comb begin
    sh_i    = int'(s1_sh_q);
    sh_amt  = 0;
    s2_wide = SAT_W'(s1_data_q);
    if (sh_i > 0) begin
      sh_amt  = (sh_i > IN_W) ? IN_W : sh_i;
      s2_wide = (s2_wide + (64'sd1 <<< (sh_amt - 1))) >>> sh_amt;
    end else if (sh_i < 0) begin
      sh_amt  = (-sh_i > OUT_W) ? OUT_W : -sh_i;
      s2_wide = s2_wide <<< sh_amt;
    end
    s2_res     = sat_signed(s2_wide, OUT_W);
    s2_valid_d = s1_valid_q;
    s2_entry_d = s2_entry_q;
    if (s1_valid_q) begin
      s2_entry_d.data = s2_res.val[OUT_W-1:0];
      s2_entry_d.q    = s1_q_q;
      s2_entry_d.sat  = s2_res.sat;
    end
  end

  sfu_sync_fifo #(
    .WIDTH($bits(entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (s2_valid_q),
    .push_data (s2_entry_q),
    .pop       (pop),
    .pop_data  (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign pop  = ~fifo_empty & ready_in;
  assign drop = s2_valid_q & fifo_full & ~pop;

  always_comb begin
    almost_full_d = (int'(fifo_count) + int'(s1_valid_q) + int'(s2_valid_q)) >= (DEPTH - 2);
    ovf_err_d     = ovf_err_q;
    if (drop) begin
      ovf_err_d = 1'b1;
    end else if (err_clr) begin
      ovf_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_data_q     <= '0;
      s1_sh_q       <= '0;
      s1_q_q        <= '0;
      s2_valid_q    <= 1'b0;
      s2_entry_q    <= '0;
      almost_full_q <= 1'b0;
      ovf_err_q     <= 1'b0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_data_q     <= s1_data_d;
      s1_sh_q       <= s1_sh_d;
      s1_q_q        <= s1_q_d;
      s2_valid_q    <= s2_valid_d;
      s2_entry_q    <= s2_entry_d;
      almost_full_q <= almost_full_d;
      ovf_err_q     <= ovf_err_d;
    end
  end

  assign data_out    = head.data;
  assign data_out_Q  = head.q;
  assign sat_out     = head.sat;
  assign valid_out   = ~fifo_empty;
  assign almost_full = almost_full_q;
  assign ovf_err     = ovf_err_q;

endmodule
